clock_period_meter: RTL and testbench

- Receiving end of a divided clock. Takes a slow toggling clock produced elsewhere, such as a divided sample/mic clock entering from another block or a pin.
- Synchronizes it into the system Clock domain and measures the half-period, in system clocks, between successive edges.
- Declares lock once the measurements are stable, and flags loss of the input clock.
- Used by the audio path to confirm the sample clock rate before recording is enabled.

---
 rtl/clock_period_meter_pkg.sv | 21 ++
 rtl/clock_period_meter_if.sv | 35 +++
 rtl/clock_period_meter_edge_sync.sv | 34 +++
 rtl/clock_period_meter.sv | 147 ++++++++++++++
 tb/tb_clock_period_meter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_period_meter_pkg
// Purpose : shared types and default settings for the clock period meter and
//           the recorder control block that checks the sample clock rate.
// Contents: FSM state encoding, default counter width / timeout / tolerance /
//           lock count.
// -----------------------------------------------------------------------------
package clock_period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   localparam int DEF_CNT_W      = 14;
   localparam int DEF_TIMEOUT    = 12000;
   localparam int DEF_TOLERANCE  = 2;
   localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clock_period_meter_if.sv
// -----------------------------------------------------------------------------
// clock_period_meter_if
// Purpose : bundles the measured clock input and the measurement results.
// Signals : ClockIn      - slow clock to measure (driven by the source side)
//           HalfPeriod   - last edge-to-edge distance in system clocks
//           PeriodValid  - one-cycle pulse when HalfPeriod updates
//           Locked       - stable period detected
//           Timeout      - input clock lost
// Modports: master = source/consumer side, slave = the meter itself.
// -----------------------------------------------------------------------------
interface clock_period_meter_if #(
   parameter int CNT_W = 14
);
   logic             ClockIn;
   logic [CNT_W-1:0] HalfPeriod;
   logic             PeriodValid;
   logic             Locked;
   logic             Timeout;

   modport master (
      output ClockIn,
      input  HalfPeriod,
      input  PeriodValid,
      input  Locked,
      input  Timeout
   );

   modport slave (
      input  ClockIn,
      output HalfPeriod,
      output PeriodValid,
      output Locked,
      output Timeout
   );
endinterface

// File: rtl/clock_period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Purpose : brings an asynchronous level into the Clock domain through two
//           flops, keeps one history flop, and strobes on any transition.
// Ports   : Clock   - system clock
//           Reset   - asynchronous active-low reset
//           async_i - asynchronous input level
//           edge_o  - one-cycle strobe on rising or falling transition
// -----------------------------------------------------------------------------
module edge_sync (
   input  logic Clock,
   input  logic Reset,
   input  logic async_i,
   output logic edge_o
);
   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s1 may be metastable; only the settled s2/s3 pair is compared.
   assign edge_o = s2_q ^ s3_q;
endmodule

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
// Purpose : measures the half-period of a slow external clock in system
//           clocks, declares lock after LOCK_COUNT consecutive matching
//           measurements and flags loss of the input clock.
// Ports   : Clock - system clock, all logic on posedge
//           Reset - asynchronous active-low reset
//           bus   - slave side of clock_period_meter_if (ClockIn in,
//                   HalfPeriod / PeriodValid / Locked / Timeout out)
// -----------------------------------------------------------------------------
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int TOLERANCE  = DEF_TOLERANCE,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic                Clock,
   input  logic                Reset,
   clock_period_meter_if.slave bus
);
   localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W:0]   TOL_V  = (CNT_W + 1)'(TOLERANCE);
   localparam logic [3:0]       LOCK_V = 4'(LOCK_COUNT);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [CNT_W-1:0] hp_q,      hp_d;
   logic             pv_q,      pv_d;
   logic             locked_q,  locked_d;
   logic             timeout_q, timeout_d;
   logic [3:0]       match_q,   match_d;
   logic             first_q,   first_d;

   logic             edge_w;
   logic [CNT_W-1:0] capture;
   logic [CNT_W:0]   cap_ext;
   logic [CNT_W:0]   hp_ext;
   logic [CNT_W:0]   diff_w;
   logic             in_tol;
   logic [3:0]       match_sat;
   logic [3:0]       match_new;

   edge_sync u_sync (
      .Clock   (Clock),
      .Reset   (Reset),
      .async_i (bus.ClockIn),
      .edge_o  (edge_w)
   );

   // Count is cleared on the edge cycle, so edges N clocks apart see Count+1 == N.
   assign capture = count_q + 1'b1;
   assign cap_ext = {1'b0, capture};
   assign hp_ext  = {1'b0, hp_q};
   // Compare first, then subtract the smaller from the larger: never negative.
   assign diff_w  = (cap_ext >= hp_ext) ? (cap_ext - hp_ext) : (hp_ext - cap_ext);
   assign in_tol  = (diff_w <= TOL_V);

   // The first capture after leaving IDLE has no predecessor to compare with.
   assign match_sat = (match_q == LOCK_V) ? match_q : (match_q + 4'd1);
   assign match_new = first_q ? 4'd0 : (in_tol ? match_sat : 4'd0);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         hp_q      <= '0;
         pv_q      <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         match_q   <= 4'd0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hp_q      <= hp_d;
         pv_q      <= pv_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         match_q   <= match_d;
         first_q   <= first_d;
      end
   end

   always_comb begin
      count_d = count_q;
      if (edge_w) begin
         count_d = '0;
      end else if (count_q != TO_V) begin
         count_d = count_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      hp_d      = hp_q;
      pv_d      = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      match_d   = match_q;
      first_d   = first_q;
      case (state_q)
         ST_IDLE: begin
            if (edge_w) begin
               state_d   = ST_ACQUIRE;
               first_d   = 1'b1;
               timeout_d = 1'b0;
               match_d   = 4'd0;
            end
         end
         ST_ACQUIRE, ST_LOCKED: begin
            // An edge always beats the timeout in the same cycle.
            if (edge_w) begin
               hp_d    = capture;
               pv_d    = 1'b1;
               first_d = 1'b0;
               match_d = match_new;
               if (state_q == ST_ACQUIRE) begin
                  if (match_new == LOCK_V) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else if (!in_tol) begin
                  state_d  = ST_ACQUIRE;
                  locked_d = 1'b0;
               end
            end else if (count_q == TO_M1) begin
               // HalfPeriod is intentionally kept as the last good value.
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = 4'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.HalfPeriod  = hp_q;
   assign bus.PeriodValid = pv_q;
   assign bus.Locked      = locked_q;
   assign bus.Timeout     = timeout_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_period_meter
// Purpose : self-checking bench for clock_period_meter. Two instances: one with
//           the default timeout, one with TIMEOUT=20 for the boundary cases.
//           An edge-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_clock_period_meter;
   localparam int CW  = 14;
   localparam int TO0 = 12000;
   localparam int TO1 = 20;
   localparam int TOL = 2;
   localparam int LK  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic cin0  = 1'b0;
   logic cin1  = 1'b0;

   always #5 clk = ~clk;

   clock_period_meter_if #(.CNT_W(CW)) bus0 ();
   clock_period_meter_if #(.CNT_W(CW)) bus1 ();

   assign bus0.ClockIn = cin0;
   assign bus1.ClockIn = cin1;

   clock_period_meter #(.CNT_W(CW), .TIMEOUT(TO0), .TOLERANCE(TOL), .LOCK_COUNT(LK)) dut0 (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus0.slave)
   );

   clock_period_meter #(.CNT_W(CW), .TIMEOUT(TO1), .TOLERANCE(TOL), .LOCK_COUNT(LK)) dut1 (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus1.slave)
   );

   int tests = 0;
   int fails = 0;

   task automatic cmp(input string name, input int u, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40)
            $display("[TB] FAIL %s u%0d: got %0d, want %0d at %0t", name, u, act, exp, $time);
      end
   endtask

   // ---------------- reference model (edge events and elapsed cycles) --------
   // Input samples seen at each posedge; an edge is visible to the meter when
   // the samples taken two and three posedges ago differ.
   bit m_hist   [2][3];
   int m_cyc    [2];
   int m_last   [2];
   bit m_active [2];
   bit m_first  [2];
   int m_match  [2];
   int e_hp     [2];
   bit e_pv     [2];
   bit e_lk     [2];
   bit e_to     [2];

   task automatic model_reset(input int u);
      for (int k = 0; k < 3; k++) m_hist[u][k] = 1'b0;
      m_cyc[u] = 0; m_last[u] = 0; m_active[u] = 0; m_first[u] = 0;
      m_match[u] = 0; e_hp[u] = 0; e_pv[u] = 0; e_lk[u] = 0; e_to[u] = 0;
   endtask

   task automatic model_step(input int u, input bit cin, input int tlim);
      bit e;
      int n;
      int d;
      e = (m_hist[u][1] != m_hist[u][2]);
      m_hist[u][2] = m_hist[u][1];
      m_hist[u][1] = m_hist[u][0];
      m_hist[u][0] = cin;
      m_cyc[u]++;
      e_pv[u] = 1'b0;
      if (e) begin
         if (!m_active[u]) begin
            m_active[u] = 1; m_first[u] = 1; e_to[u] = 0;
         end else begin
            n = m_cyc[u] - m_last[u];
            d = (n > e_hp[u]) ? n - e_hp[u] : e_hp[u] - n;
            if (m_first[u]) begin
               m_match[u] = 0; m_first[u] = 0;
            end else if (d <= TOL) begin
               m_match[u] = (m_match[u] < LK) ? m_match[u] + 1 : LK;
            end else begin
               m_match[u] = 0;
            end
            e_hp[u] = n;
            e_pv[u] = 1'b1;
            e_lk[u] = (m_match[u] == LK);
         end
         m_last[u] = m_cyc[u];
      end else if (m_active[u] && (m_cyc[u] - m_last[u] == tlim)) begin
         m_active[u] = 0; e_to[u] = 1; m_match[u] = 0; e_lk[u] = 0;
      end
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, cin0, TO0);
         model_step(1, cin1, TO1);
      end
   end

   // ---------------- per-cycle compare ---------------------------------------
   task automatic check(input int u, input logic [CW-1:0] hp, input logic pv,
                        input logic lk, input logic to);
      int xhp;
      bit xpv, xlk, xto;
      xhp = rst_n ? e_hp[u] : 0;
      xpv = rst_n ? e_pv[u] : 1'b0;
      xlk = rst_n ? e_lk[u] : 1'b0;
      xto = rst_n ? e_to[u] : 1'b0;
      cmp("HalfPeriod",  u, int'(hp), xhp);
      cmp("PeriodValid", u, int'(pv), int'(xpv));
      cmp("Locked",      u, int'(lk), int'(xlk));
      cmp("Timeout",     u, int'(to), int'(xto));
   endtask

   int pv_cnt       = 0;
   int lock_rise_pv = -1;
   int lock_fall_pv = -1;
   bit lk_prev      = 1'b0;
   bit lock_seen    = 1'b0;

   always @(negedge clk) begin
      check(0, bus0.HalfPeriod, bus0.PeriodValid, bus0.Locked, bus0.Timeout);
      check(1, bus1.HalfPeriod, bus1.PeriodValid, bus1.Locked, bus1.Timeout);
      if (rst_n && bus0.PeriodValid) begin
         pv_cnt++;
         $display("[TB] capture u0 hp=%0d locked=%0d", bus0.HalfPeriod, bus0.Locked);
      end
      if (rst_n && bus1.PeriodValid)
         $display("[TB] capture u1 hp=%0d locked=%0d", bus1.HalfPeriod, bus1.Locked);
      if (bus0.Locked && !lk_prev) lock_rise_pv = pv_cnt;
      if (!bus0.Locked && lk_prev) lock_fall_pv = pv_cnt;
      lk_prev = bus0.Locked;
      if (bus0.Locked) lock_seen = 1'b1;
   end

   // ---------------- stimulus ------------------------------------------------
   task automatic tog0(input int w);
      cin0 = ~cin0;
      repeat (w) @(posedge clk);
      #2;
   endtask

   task automatic tog1(input int w);
      cin1 = ~cin1;
      repeat (w) @(posedge clk);
      #2;
   endtask

   task automatic idle_cycles(input int w);
      repeat (w) @(posedge clk);
      #2;
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   // Second instance: timeout boundary with TIMEOUT=20.
   initial begin
      wait (rst_n == 1'b1);
      @(posedge clk); #2;
      repeat (8) tog1(20);
      idle_cycles(1);
      cmp("u1_edge_at_limit_hp", 1, int'(bus1.HalfPeriod), 20);
      cmp("u1_edge_at_limit_to", 1, int'(bus1.Timeout), 0);
      cmp("u1_edge_at_limit_lk", 1, int'(bus1.Locked), 1);
      idle_cycles(25);
      cmp("u1_lost_to", 1, int'(bus1.Timeout), 1);
      cmp("u1_lost_lk", 1, int'(bus1.Locked), 0);
      cmp("u1_lost_hp", 1, int'(bus1.HalfPeriod), 20);
      repeat (30) tog1($urandom_range(15, 22));
   end

   initial begin
      int pvs;
      int base;
      int w;
      cin0  = 1'b0;
      cin1  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      cmp("reset_hp", 0, int'(bus0.HalfPeriod), 0);
      cmp("reset_lk", 0, int'(bus0.Locked), 0);
      rst_n = 1'b1;

      // Divider LIMIT=5: lock on the fifth capture (edge 6).
      repeat (12) tog0(5);
      idle_cycles(4);
      cmp("A_hp",      0, int'(bus0.HalfPeriod), 5);
      cmp("A_lock",    0, int'(bus0.Locked), 1);
      cmp("A_rise_at", 0, lock_rise_pv, 5);

      // Switch to LIMIT=9: drop on the first 9, relock four captures later.
      repeat (8) tog0(9);
      idle_cycles(3);
      cmp("B_hp",        0, int'(bus0.HalfPeriod), 9);
      cmp("B_lock",      0, int'(bus0.Locked), 1);
      cmp("B_relock_gap", 0, lock_rise_pv - lock_fall_pv, 4);

      // Input clock stops.
      idle_cycles(TO0 + 5);
      cmp("C_to", 0, int'(bus0.Timeout), 1);
      cmp("C_lk", 0, int'(bus0.Locked), 0);
      cmp("C_hp", 0, int'(bus0.HalfPeriod), 9);
      pvs = pv_cnt;
      tog0(6);
      cmp("C_restart_to", 0, int'(bus0.Timeout), 0);
      cmp("C_restart_pv", 0, pv_cnt, pvs);

      // Jitter inside tolerance.
      for (int i = 0; i < 10; i++) tog0((i % 2 != 0) ? 102 : 100);
      cmp("D_jitter_lock", 0, int'(bus0.Locked), 1);

      // Knock it back into ACQUIRE and reset with ClockIn high.
      tog0(7);
      tog0(30);
      if (!cin0) tog0(30);
      rst_n = 1'b0;
      #1;
      cmp("E_rst_hp", 0, int'(bus0.HalfPeriod), 0);
      cmp("E_rst_pv", 0, int'(bus0.PeriodValid), 0);
      cmp("E_rst_lk", 0, int'(bus0.Locked), 0);
      cmp("E_rst_to", 0, int'(bus0.Timeout), 0);
      idle_cycles(3);
      rst_n     = 1'b1;
      pvs       = pv_cnt;
      lock_seen = 1'b0;
      idle_cycles(6);
      cmp("E_spurious_pv", 0, pv_cnt, pvs);

      // Jitter just outside tolerance: never locks.
      for (int i = 0; i < 12; i++) tog0((i % 2 != 0) ? 103 : 100);
      cmp("E_no_lock", 0, int'(lock_seen), 0);

      // Randomised half-periods around a wandering base.
      base = 20;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) base = $urandom_range(3, 60);
         w = base + $urandom_range(0, 3);
         tog0(w);
      end
      idle_cycles(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
